// File: rtl/imem_arbiter.sv
// Two-master arbiter for the single-port instruction memory: fetch (read-only) and loader (read/write).
// Fetch normally wins contention; the loader is forced through after LOADER_MAX_WAIT lost cycles.
module imem_arbiter #(
    parameter int IMEM_W          = 14,
    parameter int LOADER_MAX_WAIT = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                fetch_req_i,
    input  logic [IMEM_W-1:0]   fetch_addr_i,
    output logic                fetch_gnt_o,
    output logic                fetch_rvalid_o,
    output logic [31:0]         fetch_rdata_o,
    input  logic                ld_req_i,
    input  logic                ld_we_i,
    input  logic [IMEM_W-1:0]   ld_addr_i,
    input  logic [31:0]         ld_wdata_i,
    input  logic [3:0]          ld_be_i,
    output logic                ld_gnt_o,
    output logic                ld_rvalid_o,
    output logic [31:0]         ld_rdata_o,
    output logic                mem_en_o,
    output logic                mem_we_o,
    output logic [3:0]          mem_be_o,
    output logic [IMEM_W-3:0]   mem_addr_o,
    output logic [31:0]         mem_wdata_o,
    input  logic [31:0]         mem_rdata_i
);

    localparam int WAIT_W = $clog2(LOADER_MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(LOADER_MAX_WAIT);

    typedef enum logic [1:0] {
        RSP_NONE  = 2'd0,
        RSP_FETCH = 2'd1,
        RSP_LD    = 2'd2
    } resp_t;

    resp_t             resp_q;
    resp_t             resp_d;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;
    logic              fetch_win;
    logic              ld_win;

    // Winner selection; nobody is granted while reset is held.
    always_comb begin
        fetch_win = 1'b0;
        ld_win    = 1'b0;
        if (rst_i) begin
            fetch_win = 1'b0;
            ld_win    = 1'b0;
        end else if (fetch_req_i && ld_req_i) begin
            if (wait_q == WAIT_MAX) begin
                ld_win = 1'b1;
            end else begin
                fetch_win = 1'b1;
            end
        end else if (fetch_req_i) begin
            fetch_win = 1'b1;
        end else if (ld_req_i) begin
            ld_win = 1'b1;
        end else begin
            fetch_win = 1'b0;
            ld_win    = 1'b0;
        end
    end

    assign fetch_gnt_o = fetch_win;
    assign ld_gnt_o    = ld_win;

    // Memory command bus driven from the winner; all-zero when idle.
    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = {(IMEM_W-2){1'b0}};
        mem_wdata_o = 32'h0000_0000;
        if (fetch_win) begin
            mem_en_o   = 1'b1;
            mem_be_o   = 4'hF;
            mem_addr_o = fetch_addr_i[IMEM_W-1:2];
        end else if (ld_win) begin
            mem_en_o    = 1'b1;
            mem_we_o    = ld_we_i;
            mem_be_o    = ld_be_i;
            mem_addr_o  = ld_addr_i[IMEM_W-1:2];
            mem_wdata_o = ld_wdata_i;
        end else begin
            mem_en_o = 1'b0;
        end
    end

    // Next-state for the starvation counter and the response tracker.
    always_comb begin
        wait_d = {WAIT_W{1'b0}};
        resp_d = RSP_NONE;
        // fetch_win under contention implies wait_q < WAIT_MAX, so no overflow
        if (fetch_req_i && ld_req_i && fetch_win) begin
            wait_d = wait_q + WAIT_W'(1);
        end else begin
            wait_d = {WAIT_W{1'b0}};
        end
        if (fetch_win) begin
            resp_d = RSP_FETCH;
        end else if (ld_win && !ld_we_i) begin
            resp_d = RSP_LD;
        end else begin
            resp_d = RSP_NONE;
        end
    end

    // State registers; async reset also discards any in-flight read.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_q <= {WAIT_W{1'b0}};
            resp_q <= RSP_NONE;
        end else begin
            wait_q <= wait_d;
            resp_q <= resp_d;
        end
    end

    // Route returning read data to the master that issued the read.
    always_comb begin
        fetch_rvalid_o = 1'b0;
        fetch_rdata_o  = 32'h0000_0000;
        ld_rvalid_o    = 1'b0;
        ld_rdata_o     = 32'h0000_0000;
        case (resp_q)
            RSP_FETCH: begin
                fetch_rvalid_o = 1'b1;
                fetch_rdata_o  = mem_rdata_i;
            end
            RSP_LD: begin
                ld_rvalid_o = 1'b1;
                ld_rdata_o  = mem_rdata_i;
            end
            default: begin
                fetch_rvalid_o = 1'b0;
                ld_rvalid_o    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: behavioural memory, arbitration model and a
// read-response scoreboard queue.
module tb_imem_arbiter;

    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [13:0] fetch_addr;
    logic        fetch_gnt;
    logic        fetch_rvalid;
    logic [31:0] fetch_rdata;
    logic        ld_req;
    logic        ld_we;
    logic [13:0] ld_addr;
    logic [31:0] ld_wdata;
    logic [3:0]  ld_be;
    logic        ld_gnt;
    logic        ld_rvalid;
    logic [31:0] ld_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem  [0:4095];
    logic [31:0] gold [0:4095];

    typedef struct {
        logic        is_ld;
        logic [31:0] data;
    } rsp_t;
    rsp_t sbq[$];

    int   n_pass = 0;
    int   n_total = 0;
    int   mw = 0;
    logic last_ld_gnt;
    logic [11:0] pat;

    imem_arbiter #(.IMEM_W(14), .LOADER_MAX_WAIT(MAXW)) dut (
        .clk_i(clk), .rst_i(rst),
        .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_gnt_o(fetch_gnt),
        .fetch_rvalid_o(fetch_rvalid), .fetch_rdata_o(fetch_rdata),
        .ld_req_i(ld_req), .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_wdata_i(ld_wdata),
        .ld_be_i(ld_be), .ld_gnt_o(ld_gnt), .ld_rvalid_o(ld_rvalid), .ld_rdata_o(ld_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory with byte-enabled writes.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        else
            n_pass++;
    endtask

    // One clock cycle: check responses due now, drive a request, check grant/command, advance.
    task automatic cyc(input logic freq, input logic [13:0] faddr, input logic lreq,
                       input logic lwe, input logic [13:0] laddr, input logic [31:0] lwd,
                       input logic [3:0] lbe);
        rsp_t        e;
        logic        ef;
        logic        el;
        logic [11:0] ea;
        logic [11:0] w;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("fetch_rvalid", 32'(fetch_rvalid), 32'(!e.is_ld));
            check("fetch_rdata", fetch_rdata, e.is_ld ? 32'd0 : e.data);
            check("ld_rvalid", 32'(ld_rvalid), 32'(e.is_ld));
            check("ld_rdata", ld_rdata, e.is_ld ? e.data : 32'd0);
        end else begin
            check("fetch_rvalid_idle", 32'(fetch_rvalid), 32'd0);
            check("fetch_rdata_idle", fetch_rdata, 32'd0);
            check("ld_rvalid_idle", 32'(ld_rvalid), 32'd0);
            check("ld_rdata_idle", ld_rdata, 32'd0);
        end
        fetch_req = freq; fetch_addr = faddr;
        ld_req = lreq; ld_we = lwe; ld_addr = laddr; ld_wdata = lwd; ld_be = lbe;
        #1;
        ef = freq && !(lreq && mw == MAXW);
        el = lreq && !ef;
        ea = ef ? faddr[13:2] : (el ? laddr[13:2] : 12'd0);
        check("fetch_gnt", 32'(fetch_gnt), 32'(ef));
        check("ld_gnt", 32'(ld_gnt), 32'(el));
        check("mem_en", 32'(mem_en), 32'(ef | el));
        check("mem_addr", 32'(mem_addr), 32'(ea));
        check("mem_we", 32'(mem_we), 32'(el & lwe));
        check("mem_be", 32'(mem_be), ef ? 32'hF : (el ? 32'(lbe) : 32'd0));
        check("mem_wdata", mem_wdata, el ? lwd : 32'd0);
        last_ld_gnt = ld_gnt;
        if (ef) begin
            sbq.push_back('{is_ld: 1'b0, data: gold[faddr[13:2]]});
        end else if (el && !lwe) begin
            sbq.push_back('{is_ld: 1'b1, data: gold[laddr[13:2]]});
        end else if (el) begin
            w = laddr[13:2];
            for (int b = 0; b < 4; b++)
                if (lbe[b]) gold[w][8*b +: 8] = lwd[8*b +: 8];
        end
        if (freq && lreq && ef) mw++;
        else mw = 0;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        cyc(1'b0, 14'd0, 1'b0, 1'b0, 14'd0, 32'd0, 4'h0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            mem[i]  = (32'(i) * 32'h9E37_79B1) ^ 32'h1234_5678;
            gold[i] = (32'(i) * 32'h9E37_79B1) ^ 32'h1234_5678;
        end
        mem_rdata = 32'd0;
        rst = 1'b1;
        fetch_req = 1'b1; fetch_addr = 14'h0010;
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 14'h0020; ld_wdata = 32'd0; ld_be = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        // Reset holds everything quiet even with both masters requesting
        check("rst_fetch_gnt", 32'(fetch_gnt), 32'd0);
        check("rst_ld_gnt", 32'(ld_gnt), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_fetch_rvalid", 32'(fetch_rvalid), 32'd0);
        check("rst_ld_rvalid", 32'(ld_rvalid), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        fetch_req = 1'b0; ld_req = 1'b0;
        rst = 1'b0;

        cyc(1'b1, 14'h0010, 1'b0, 1'b0, 14'd0, 32'd0, 4'h0);
        idle();
        check("t2_word4_const", gold[4], (32'd4 * 32'h9E37_79B1) ^ 32'h1234_5678);

        cyc(1'b0, 14'd0, 1'b1, 1'b1, 14'h0020, 32'hDEAD_BEEF, 4'b0011);
        cyc(1'b1, 14'h0020, 1'b0, 1'b0, 14'd0, 32'd0, 4'h0);
        idle();
        check("t3_merge", gold[8], {((32'd8 * 32'h9E37_79B1) ^ 32'h1234_5678) >> 16, 16'hBEEF});
        cyc(1'b0, 14'd0, 1'b1, 1'b0, 14'h0022, 32'd0, 4'h0);
        idle();

        cyc(1'b1, 14'h3FFF, 1'b0, 1'b0, 14'd0, 32'd0, 4'h0);
        cyc(1'b0, 14'd0, 1'b1, 1'b1, 14'h3FFE, 32'h0BAD_F00D, 4'hF);
        cyc(1'b1, 14'h3FFC, 1'b0, 1'b0, 14'd0, 32'd0, 4'h0);
        idle();

        pat = 12'd0;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b1, 14'(i * 4), 1'b1, 1'b0, 14'(14'h0100 + i * 4), 32'd0, 4'h0);
            pat[i] = last_ld_gnt;
        end
        idle();
        check("t4_pattern", 32'(pat), 32'h0000_0210);

        for (int i = 0; i < 4; i++)
            cyc(1'b1, 14'(i * 4), 1'b0, 1'b0, 14'd0, 32'd0, 4'h0);
        idle();

        for (int i = 0; i < 60; i++)
            cyc(1'($urandom_range(0, 1)), 14'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 14'($urandom_range(0, 255)), $urandom, 4'($urandom));
        idle();
        idle();

        // Reset lands between a fetch grant and its response
        fetch_req = 1'b1; fetch_addr = 14'h0040;
        #1;
        check("t6_gnt", 32'(fetch_gnt), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_gnt_in_rst", 32'(fetch_gnt), 32'd0);
        check("t6_en_in_rst", 32'(mem_en), 32'd0);
        fetch_req = 1'b0;
        @(posedge clk); #1;
        check("t6_no_rvalid", 32'(fetch_rvalid), 32'd0);
        sbq.delete();
        mw = 0;
        rst = 1'b0;
        @(posedge clk); #1;
        check("t6_no_rvalid_after", 32'(fetch_rvalid), 32'd0);
        cyc(1'b1, 14'h0040, 1'b0, 1'b0, 14'd0, 32'd0, 4'h0);
        idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
